// File: rtl/pipe_position.sv
// Horizontal position, gap height and speed of one scrolling pipe.
// Moves are ungated here; oPipe_Wait tells the controller when the next move is due.
module pipe_position #(
  parameter int SCREEN_W    = 640,
  parameter int PIPE_W      = 64,
  parameter int TICK_PERIOD = 100000,
  parameter int SPEED_INIT  = 1,
  parameter int SPEED_MAX   = 15,
  parameter int GAP_MIN     = 80,
  parameter int GAP_MAX     = 400,
  parameter int GAP_DEFAULT = 240
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iPipe_Pos_Move,
  input  logic        iPipe_Pos_Rst,
  input  logic        iPipe_Speed_Inc,
  input  logic [8:0]  iRnd_Value,
  output logic [10:0] oPipe_X,
  output logic [8:0]  oGap_Y,
  output logic [3:0]  oSpeed,
  output logic        oPipe_Wait,
  output logic        oPipe_Gone
);

  localparam int TICK_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  localparam logic [10:0]       START_X     = 11'(SCREEN_W + PIPE_W);
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_PERIOD - 1);
  localparam logic [8:0]        GAP_LO      = 9'(GAP_MIN);
  localparam logic [8:0]        GAP_HI      = 9'(GAP_MAX);
  localparam logic [8:0]        GAP_RST     = 9'(GAP_DEFAULT);
  localparam logic [3:0]        SPD_INIT    = 4'(SPEED_INIT);
  localparam logic [3:0]        SPD_MAX     = 4'(SPEED_MAX);

  logic [TICK_W-1:0] tickCnt;
  logic [10:0]       speedWide;
  logic [10:0]       movedX;
  logic [8:0]        gapClamped;

  assign speedWide = {7'b0, oSpeed};

  // Saturate at the left edge instead of wrapping to a huge X.
  assign movedX = (oPipe_X <= speedWide) ? 11'd0 : (oPipe_X - speedWide);

  always_comb begin
    gapClamped = iRnd_Value;
    if (iRnd_Value < GAP_LO)
      gapClamped = GAP_LO;
    else if (iRnd_Value > GAP_HI)
      gapClamped = GAP_HI;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oPipe_X <= START_X;
      oGap_Y  <= GAP_RST;
      oSpeed  <= SPD_INIT;
      tickCnt <= TICK_RELOAD;
    end else begin
      if (iPipe_Pos_Rst) begin
        oPipe_X <= START_X;
        oGap_Y  <= gapClamped;
        tickCnt <= TICK_RELOAD;
      end else if (iPipe_Pos_Move) begin
        oPipe_X <= movedX;
        tickCnt <= TICK_RELOAD;
      end else if (tickCnt != '0) begin
        tickCnt <= tickCnt - 1'b1;
      end

      // Independent of move/respawn; a same-cycle move already used the old speed.
      if (iPipe_Speed_Inc)
        oSpeed <= (oSpeed < SPD_MAX) ? (oSpeed + 4'd1) : SPD_MAX;
    end
  end

  assign oPipe_Wait = (tickCnt != '0);
  assign oPipe_Gone = (oPipe_X == 11'd0);

endmodule

// File: tb/tb_pipe_position.sv
// Directed bench for pipe_position with TICK_PERIOD=4 and default geometry.
module tb_pipe_position;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iPipe_Pos_Move = 1'b0;
  logic        iPipe_Pos_Rst = 1'b0;
  logic        iPipe_Speed_Inc = 1'b0;
  logic [8:0]  iRnd_Value = 9'd0;
  logic [10:0] oPipe_X;
  logic [8:0]  oGap_Y;
  logic [3:0]  oSpeed;
  logic        oPipe_Wait;
  logic        oPipe_Gone;

  int nAsserts = 0;
  int nFails = 0;

  pipe_position #(.TICK_PERIOD(4)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .iPipe_Pos_Move(iPipe_Pos_Move),
    .iPipe_Pos_Rst(iPipe_Pos_Rst),
    .iPipe_Speed_Inc(iPipe_Speed_Inc),
    .iRnd_Value(iRnd_Value),
    .oPipe_X(oPipe_X),
    .oGap_Y(oGap_Y),
    .oSpeed(oSpeed),
    .oPipe_Wait(oPipe_Wait),
    .oPipe_Gone(oPipe_Gone)
  );

  always #5 iClk = ~iClk;

  // Advance one clock; outputs are settled 1 ns after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int x, input int gap, input int spd,
                          input int wt, input int gone);
    check({tag, ".x"}, 32'(oPipe_X), 32'(x));
    check({tag, ".gap"}, 32'(oGap_Y), 32'(gap));
    check({tag, ".speed"}, 32'(oSpeed), 32'(spd));
    check({tag, ".wait"}, 32'(oPipe_Wait), 32'(wt));
    check({tag, ".gone"}, 32'(oPipe_Gone), 32'(gone));
  endtask

  initial begin
    #2;
    // Reset held 3 cycles
    iRst = 1'b1;
    step(3);
    iRst = 1'b0;
    checkAll("reset", 704, 240, 1, 1, 0);
    step(2);
    check("rst_wait_2", 32'(oPipe_Wait), 32'd1);
    step(1);
    check("rst_wait_3", 32'(oPipe_Wait), 32'd0);
    step(2);
    check("rst_wait_hold0", 32'(oPipe_Wait), 32'd0);

    // Single move at speed 1, gap must ignore the random input
    iRnd_Value = 9'd123;
    iPipe_Pos_Move = 1'b1;
    step(1);
    iPipe_Pos_Move = 1'b0;
    checkAll("move1", 703, 240, 1, 1, 0);
    step(2);
    check("move1_wait_2", 32'(oPipe_Wait), 32'd1);
    step(1);
    check("move1_wait_3", 32'(oPipe_Wait), 32'd0);

    // Three speed increments, then a move of 4
    iPipe_Speed_Inc = 1'b1;
    step(3);
    iPipe_Speed_Inc = 1'b0;
    check("speed4", 32'(oSpeed), 32'd4);
    iPipe_Pos_Move = 1'b1;
    step(1);
    iPipe_Pos_Move = 1'b0;
    check("move4_x", 32'(oPipe_X), 32'd699);
    iPipe_Speed_Inc = 1'b1;
    step(20);
    iPipe_Speed_Inc = 1'b0;
    check("speed_sat", 32'(oSpeed), 32'd15);
    check("gap_unchanged", 32'(oGap_Y), 32'd240);

    // Fresh reset; increment and move together -> move uses old speed 1
    iRst = 1'b1;
    step(1);
    iRst = 1'b0;
    iPipe_Speed_Inc = 1'b1;
    iPipe_Pos_Move = 1'b1;
    step(1);
    iPipe_Speed_Inc = 1'b0;
    iPipe_Pos_Move = 1'b0;
    check("incmove_x", 32'(oPipe_X), 32'd703);
    check("incmove_speed", 32'(oSpeed), 32'd2);
    iPipe_Speed_Inc = 1'b1;
    step(2);
    iPipe_Speed_Inc = 1'b0;
    check("speed4_b", 32'(oSpeed), 32'd4);

    // 175 back-to-back moves of 4 (ungated by wait): 703 -> 3
    iPipe_Pos_Move = 1'b1;
    step(175);
    iPipe_Pos_Move = 1'b0;
    check("x_at_3", 32'(oPipe_X), 32'd3);
    check("not_gone_at_3", 32'(oPipe_Gone), 32'd0);
    iPipe_Pos_Move = 1'b1;
    step(1);
    check("x_sat0", 32'(oPipe_X), 32'd0);
    check("gone", 32'(oPipe_Gone), 32'd1);
    step(1);
    iPipe_Pos_Move = 1'b0;
    check("x_nowrap", 32'(oPipe_X), 32'd0);
    check("gone_hold", 32'(oPipe_Gone), 32'd1);

    // Respawn with clamping
    iRnd_Value = 9'd20;
    iPipe_Pos_Rst = 1'b1;
    step(1);
    iPipe_Pos_Rst = 1'b0;
    checkAll("respawn_lo", 704, 80, 4, 1, 0);
    step(3);
    iRnd_Value = 9'd500;
    iPipe_Pos_Rst = 1'b1;
    step(1);
    iPipe_Pos_Rst = 1'b0;
    checkAll("respawn_hi", 704, 400, 4, 1, 0);
    iRnd_Value = 9'd300;
    iPipe_Pos_Rst = 1'b1;
    step(1);
    iPipe_Pos_Rst = 1'b0;
    checkAll("respawn_mid", 704, 300, 4, 1, 0);

    // Respawn beats a same-cycle move
    iPipe_Pos_Move = 1'b1;
    step(1);
    iPipe_Pos_Move = 1'b0;
    check("pre_prio_x", 32'(oPipe_X), 32'd700);
    iRnd_Value = 9'd81;
    iPipe_Pos_Rst = 1'b1;
    iPipe_Pos_Move = 1'b1;
    step(1);
    iPipe_Pos_Rst = 1'b0;
    iPipe_Pos_Move = 1'b0;
    checkAll("rst_prio", 704, 81, 4, 1, 0);

    // Move to 700, then iRst during move/inc/respawn requests
    iPipe_Pos_Move = 1'b1;
    step(1);
    iPipe_Pos_Move = 1'b0;
    step(3);
    check("pre_rst_wait", 32'(oPipe_Wait), 32'd0);
    iRst = 1'b1;
    iPipe_Pos_Move = 1'b1;
    iPipe_Speed_Inc = 1'b1;
    iPipe_Pos_Rst = 1'b1;
    iRnd_Value = 9'd300;
    step(1);
    iRst = 1'b0;
    iPipe_Pos_Move = 1'b0;
    iPipe_Speed_Inc = 1'b0;
    iPipe_Pos_Rst = 1'b0;
    checkAll("rst_override", 704, 240, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
